mtr_pwm_drv: RTL and testbench
==============================

// Module: mtr_pwm_drv
// PURPOSE
//  Consumer of the balance controller's motor command: takes an 11-bit unsigned duty
//  and a direction bit, and drives one H-bridge with glitch-free PWM.
//  Duty and direction are sampled only at PWM period boundaries.
//  Every reversal passes through a forced-coast dead period, so both legs are never driven.
//  One instance per wheel; sits between the PID/duty stage and the motor driver pins.
// PARAMETERS
//  MAX_DUTY      11'h7C0  clamp ceiling applied to sampled duty (caps high time per period)
//  DEAD_PERIODS  1        full PWM periods of coast (both outputs low) on a direction change
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  en           in   1   drive enable; low forces coast
//  mtr_duty     in   11  unsigned duty magnitude, in counts of 2048 per period
//  rev          in   1   requested direction; 1 = reverse
//  PWM_fwd      out  1   forward-leg PWM (registered)
//  PWM_rev      out  1   reverse-leg PWM (registered)
//  prd_strt     out  1   one-cycle pulse in the first cycle of each PWM period
//  dir_cur      out  1   direction actually being driven
// BEHAVIOUR
//  Reset (async assert, sync release) values:
//   cnt=0, duty_lat=0, dir_cur=0, dead_cnt=0, state=IDLE.
//   PWM_fwd=0, PWM_rev=0, prd_strt=0.
//  Counter:
//   cnt is 11 bits, free-running 0..2047, period = 2048 clk.
//   wrap = (cnt==11'h7FF); prd_strt registered from wrap, so it is high while cnt==0.
//  Sampling at wrap (only there):
//   duty_lat <= (mtr_duty > MAX_DUTY) ? MAX_DUTY : mtr_duty.
//   rev_lat <= rev.
//   Mid-period changes of mtr_duty or rev are ignored until the next wrap.
//  Compare:
//   pwm_raw = (cnt < duty_lat), strict.
//   duty 0 -> output never high; duty D -> high exactly D clk per period.
//   Outputs are registered from pwm_raw, so they lag cnt by 1 clk.
//  State machine (transitions evaluated at wrap unless stated):
//   IDLE:  outputs low.
//          en=1 at wrap -> DRIVE, with dir_cur <= rev.
//   DRIVE: PWM_fwd = pwm_raw & ~dir_cur; PWM_rev = pwm_raw & dir_cur.
//          At wrap, sampled rev != dir_cur -> DEAD, dead_cnt <= DEAD_PERIODS-1.
//   DEAD:  both outputs low for whole periods.
//          At wrap, dead_cnt==0 -> DRIVE, dir_cur <= rev sampled at that wrap.
//          Otherwise dead_cnt decrements.
//          rev reverting to dir_cur during DEAD still completes the dead time.
//   Any state: en=0 -> IDLE on the next clk (not deferred to wrap).
//          Outputs low on the following clk; dead_cnt cleared.
//  Safety invariant: PWM_fwd & PWM_rev is never 1 in any cycle, including at reset
//   release and on en toggles.
//  Reset mid-operation: everything returns to reset values immediately; the counter
//   restarts from 0.
//  Arithmetic: all unsigned 11-bit; no wrap on clamp; dead_cnt is $clog2(DEAD_PERIODS+1) bits.
// STRUCTURE
//  Shared package mtr_pkg:
//   drv_state_t enum {IDLE, DRIVE, DEAD}.
//   PWM_W = 11, PWM_PERIOD = 2048.
//   Default MAX_DUTY value (also used by the duty stage).
//  Sub-module pwm11: counter + duty_lat register + comparator; ports clk, rst_n,
//   duty_in, wrap, pwm_raw.
//  The FSM, direction steering and output registers stay in mtr_pwm_drv.
// TESTING
//  1. Reset: hold rst_n=0 with en=1, duty=0x400 -> both outputs 0, prd_strt 0; after
//     release, first prd_strt at clk 2048.
//  2. en=1, rev=0, duty=0x400 -> from the period after the first wrap, PWM_fwd high
//     1024 clk of every 2048 and PWM_rev always 0.
//  3. duty 0x400 -> 0x100 changed at cnt=0x200 -> current period stays 1024 high;
//     the next period is 256 high.
//  4. DRIVE fwd at duty=0x3D4, rev 0->1 mid-period:
//     - rest of the period stays fwd;
//     - the next 2048 clk are both low;
//     - then PWM_rev is high 980 clk per period;
//     - dir_cur=1.
//  5. duty=0x7FF with MAX_DUTY=0x7C0 -> high 1984 clk per period; duty=0 -> never high.
//  6. en dropped while PWM_fwd is high -> both low within 2 clk, state IDLE; re-enable
//     resumes only at the next wrap; an assertion checks PWM_fwd&PWM_rev==0 every cycle.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared types and constants for the wheel motor PWM path.
package mtr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } drv_state_t;

    localparam int PWM_W      = 11;
    localparam int PWM_PERIOD = 2048;

    // Duty ceiling shared with the upstream duty stage.
    localparam logic [PWM_W-1:0] MAX_DUTY_DEF = 11'h7C0;

endpackage

// File: rtl/pwm11.sv
// 11-bit free-running PWM core: period counter, duty latched once per period, comparator.
module pwm11
    import mtr_pkg::*;
#(
    parameter logic [PWM_W-1:0] MAX_DUTY = MAX_DUTY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty_in,
    output logic             wrap,
    output logic             pwm_raw
);

    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_lat;

    function automatic logic [PWM_W-1:0] sat_duty(input logic [PWM_W-1:0] d);
        return (d > MAX_DUTY) ? MAX_DUTY : d;
    endfunction

    assign wrap    = (cnt == CNT_LAST);
    assign pwm_raw = (cnt < duty_lat);

    // Duty only moves at the period boundary so a period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            duty_lat <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (wrap) begin
                duty_lat <= sat_duty(duty_in);
            end
        end
    end

endmodule

// File: rtl/mtr_pwm_drv.sv
// H-bridge PWM driver: period-aligned duty/direction sampling with forced coast on reversal.
module mtr_pwm_drv
    import mtr_pkg::*;
#(
    parameter logic [PWM_W-1:0] MAX_DUTY     = MAX_DUTY_DEF,
    parameter int               DEAD_PERIODS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PWM_W-1:0] mtr_duty,
    input  logic             rev,
    output logic             PWM_fwd,
    output logic             PWM_rev,
    output logic             prd_strt,
    output logic             dir_cur
);

    localparam int              DC_W      = (DEAD_PERIODS < 1) ? 1 : $clog2(DEAD_PERIODS + 1);
    localparam logic [DC_W-1:0] DEAD_INIT = DC_W'(DEAD_PERIODS - 1);

    drv_state_t      state;
    logic [DC_W-1:0] dead_cnt;
    logic            wrap;
    logic            pwm_raw;

    pwm11 #(
        .MAX_DUTY (MAX_DUTY)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty_in (mtr_duty),
        .wrap    (wrap),
        .pwm_raw (pwm_raw)
    );

    // Both legs derive from the single dir_cur bit, so they can never be high together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dead_cnt <= '0;
            dir_cur  <= 1'b0;
            PWM_fwd  <= 1'b0;
            PWM_rev  <= 1'b0;
            prd_strt <= 1'b0;
        end else begin
            prd_strt <= wrap;
            PWM_fwd  <= (state == DRIVE) & pwm_raw & ~dir_cur;
            PWM_rev  <= (state == DRIVE) & pwm_raw & dir_cur;

            if (!en) begin
                state    <= IDLE;
                dead_cnt <= '0;
            end else if (wrap) begin
                case (state)
                    IDLE: begin
                        state   <= DRIVE;
                        dir_cur <= rev;
                    end
                    DRIVE: begin
                        if (rev != dir_cur) begin
                            state    <= DEAD;
                            dead_cnt <= DEAD_INIT;
                        end
                    end
                    DEAD: begin
                        if (dead_cnt == '0) begin
                            state   <= DRIVE;
                            dir_cur <= rev;
                        end else begin
                            dead_cnt <= dead_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Period-level self-checking bench for mtr_pwm_drv with directed and randomized periods.
module tb_mtr_pwm_drv;
    import mtr_pkg::*;

    localparam logic [10:0] MAXD   = 11'h7C0;
    localparam int          DEADP  = 1;
    localparam int          NPER   = 30;
    localparam int          PER    = 2048;
    localparam int          M_IDLE = 0;
    localparam int          M_DRV  = 1;
    localparam int          M_DEAD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        rev = 1'b0;
    logic [10:0] mtr_duty = '0;
    logic        PWM_fwd, PWM_rev, prd_strt, dir_cur;

    always #5 clk = ~clk;

    mtr_pwm_drv #(
        .MAX_DUTY     (MAXD),
        .DEAD_PERIODS (DEADP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mtr_duty (mtr_duty),
        .rev      (rev),
        .PWM_fwd  (PWM_fwd),
        .PWM_rev  (PWM_rev),
        .prd_strt (prd_strt),
        .dir_cur  (dir_cur)
    );

    always @(negedge clk) begin
        assert (!(PWM_fwd && PWM_rev));
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit en;
        int duty;
        bit rev;
        int mid_at;
        int mid_duty;
        bit mid_rev;
        int drop_at;
    } plan_t;

    plan_t plan[NPER+1];

    function automatic plan_t mk(input bit e, input int d, input bit r);
        plan_t p;
        p.en = e; p.duty = d; p.rev = r;
        p.mid_at = 0; p.mid_duty = 0; p.mid_rev = 1'b0; p.drop_at = 0;
        return p;
    endfunction

    // Reference: what each period should look like, decided once per boundary.
    int m_mode = M_IDLE;
    int m_dir  = 0;
    int m_dead = 0;

    task automatic model_boundary(input plan_t p);
        if (!p.en) begin
            m_mode = M_IDLE;
            m_dead = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_DRV;
            m_dir  = p.rev;
        end else if (m_mode == M_DRV) begin
            if (int'(p.rev) != m_dir) begin
                m_mode = M_DEAD;
                m_dead = DEADP - 1;
            end
        end else begin
            if (m_dead == 0) begin
                m_mode = M_DRV;
                m_dir  = p.rev;
            end else begin
                m_dead--;
            end
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic apply_wrap_vals(input plan_t p);
        en       = p.en;
        mtr_duty = 11'(p.duty);
        rev      = p.rev;
    endtask

    initial begin
        int    lim_f, lim_r, dutyc, exp_dir, dir_obs;
        int    cnt_f, cnt_r, e_shape, e_p, e_b;
        bit    prev_rev;
        plan_t p;

        // Directed periods first, then randomized ones.
        plan[0]  = mk(1, 'h400, 0);
        plan[1]  = mk(1, 'h400, 0);
        plan[2]  = mk(1, 'h400, 0); plan[2].mid_at = 'h200; plan[2].mid_duty = 'h100;
        plan[3]  = mk(1, 'h100, 0);
        plan[4]  = mk(1, 'h3D4, 0); plan[4].mid_at = 500; plan[4].mid_duty = 'h3D4; plan[4].mid_rev = 1;
        plan[5]  = mk(1, 'h3D4, 1);
        plan[6]  = mk(1, 'h3D4, 1);
        plan[7]  = mk(1, 'h7FF, 1);
        plan[8]  = mk(1, 0, 1);
        plan[9]  = mk(1, 'h400, 0); plan[9].mid_at = 100; plan[9].mid_duty = 'h400; plan[9].mid_rev = 1;
        plan[10] = mk(1, 'h200, 1);
        plan[11] = mk(1, 'h600, 1); plan[11].drop_at = 300;
        plan[12] = mk(1, 'h400, 0);
        plan[13] = mk(1, 'h400, 0); plan[13].drop_at = 100;
        prev_rev = 1'b0;
        for (int k = 14; k <= NPER; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            p = mk($urandom_range(0, 7) != 0, 0, prev_rev);
            if (sel == 0)      p.duty = 0;
            else if (sel == 1) p.duty = $urandom_range(1984, 2047);
            else               p.duty = $urandom_range(1, 1983);
            if ($urandom_range(0, 2) == 0) p.rev = ~prev_rev;
            prev_rev = p.rev;
            if ($urandom_range(0, 1) == 1) begin
                p.mid_at   = $urandom_range(1, 2040);
                p.mid_duty = $urandom_range(0, 2047);
                p.mid_rev  = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 5) == 0) p.drop_at = $urandom_range(1, 1900);
            plan[k] = p;
        end

        // Reset held with drive requested.
        en = 1'b1; mtr_duty = 11'h400; rev = 1'b0;
        #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst PWM_fwd", PWM_fwd, 0);
        chk("rst PWM_rev", PWM_rev, 0);
        chk("rst prd_strt", prd_strt, 0);
        chk("rst dir_cur", dir_cur, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int k = 0; k < NPER; k++) begin
            if (k > 0) model_boundary(plan[k]);
            dutyc   = imin(plan[k].duty, int'(MAXD));
            lim_f   = (m_mode == M_DRV && m_dir == 0) ? dutyc : 0;
            lim_r   = (m_mode == M_DRV && m_dir == 1) ? dutyc : 0;
            if (plan[k].drop_at > 0) begin
                lim_f = imin(lim_f, plan[k].drop_at + 1);
                lim_r = imin(lim_r, plan[k].drop_at + 1);
            end
            exp_dir = m_dir;
            cnt_f = 0; cnt_r = 0; e_shape = 0; e_p = 0; e_b = 0; dir_obs = 0;
            for (int i = 1; i <= PER; i++) begin
                @(posedge clk);
                #1;
                if (PWM_fwd !== (i <= lim_f)) e_shape++;
                if (PWM_rev !== (i <= lim_r)) e_shape++;
                if (prd_strt !== (i == PER)) e_p++;
                if (PWM_fwd && PWM_rev) e_b++;
                cnt_f += int'(PWM_fwd);
                cnt_r += int'(PWM_rev);
                if (i == 1) dir_obs = int'(dir_cur);
                if (i == plan[k].mid_at) begin
                    mtr_duty = 11'(plan[k].mid_duty);
                    rev      = plan[k].mid_rev;
                end
                if (plan[k].drop_at > 0 && i == plan[k].drop_at) en = 1'b0;
                if (plan[k].drop_at > 0 && i == plan[k].drop_at + 10) en = 1'b1;
                if (i == PER - 1) apply_wrap_vals(plan[k+1]);
            end
            if (plan[k].drop_at > 0) begin
                m_mode = M_IDLE;
                m_dead = 0;
            end
            chk($sformatf("p%0d fwd_high", k), cnt_f, lim_f);
            chk($sformatf("p%0d rev_high", k), cnt_r, lim_r);
            chk($sformatf("p%0d shape_err", k), e_shape, 0);
            chk($sformatf("p%0d prd_strt_err", k), e_p, 0);
            chk($sformatf("p%0d both_high", k), e_b, 0);
            chk($sformatf("p%0d dir_cur", k), dir_obs, exp_dir);
        end

        // Reset in mid-period: immediate return to reset values, counter restarts.
        repeat (300) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst PWM_fwd", PWM_fwd, 0);
        chk("midrst PWM_rev", PWM_rev, 0);
        chk("midrst prd_strt", prd_strt, 0);
        chk("midrst dir_cur", dir_cur, 0);
        @(negedge clk) rst_n = 1'b1;
        e_p = 0;
        for (int i = 1; i <= PER; i++) begin
            @(posedge clk);
            #1;
            if (prd_strt !== (i == PER)) e_p++;
        end
        chk("midrst prd_strt_err", e_p, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
